coi3_conv_ctrl: RTL and testbench

Conversion sequencer for the third-order CoI3 integrator filter. Accepts a start command and a decimation length, resets and releases the filter, and watches for `done` under a watchdog. It captures the 28-bit result into a one-entry valid/ready output buffer and optionally re-arms for back-to-back conversions. Sits between the system control logic and one COI3 instance, on the same clock.

---
 rtl/coi3_pkg.sv | 17 +
 rtl/coi3_result_buf.sv | 39 +++
 rtl/coi3_conv_ctrl.sv | 137 +++++++++++++
 tb/tb_coi3_conv_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coi3_pkg.sv
// Shared types and constants for the CoI3 conversion sequencer.
package coi3_pkg;

  localparam int COI3_N_W      = 11;
  localparam int COI3_D_W      = 28;
  localparam int COI3_SYNC_LAT = 4;
  localparam int COI3_N_MIN    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARM,
    ST_RUN,
    ST_CAPTURE
  } coi3_ctrl_state_t;

endpackage

// File: rtl/coi3_result_buf.sv
// One-entry valid/ready result register; flags a load that finds it full.
module coi3_result_buf
  import coi3_pkg::*;
#(
  parameter int D_W = COI3_D_W
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           i_load,
  input  logic [D_W-1:0] i_din,
  input  logic           i_ready,
  output logic [D_W-1:0] o_data,
  output logic           o_valid,
  output logic           o_ovr
);

  logic [D_W-1:0] r_data;
  logic           r_valid;
  logic           w_take;

  // A full buffer can still accept a load when it is being drained that cycle.
  assign w_take  = i_load && (!r_valid || i_ready);
  assign o_ovr   = i_load && r_valid && !i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_data  <= i_din;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/coi3_conv_ctrl.sv
// Conversion sequencer for one CoI3 filter: reset/release, watchdog, result capture.
//   state   | meaning
//   IDLE    | filter held in reset, waiting for start
//   CLEAR   | filter held in reset for two cycles
//   ARM     | load watchdog, release filter on exit
//   RUN     | wait for filter done under watchdog
//   CAPTURE | push result into buffer, re-arm if cont
module coi3_conv_ctrl
  import coi3_pkg::*;
#(
  parameter int N_W       = COI3_N_W,
  parameter int D_W       = COI3_D_W,
  parameter int TO_MARGIN = 8
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           start,
  input  logic           cont,
  input  logic           abort,
  input  logic [N_W-1:0] n_cfg,
  output logic           busy,
  output logic           flt_rst,
  output logic [N_W-1:0] flt_n,
  input  logic           flt_done,
  input  logic [D_W-1:0] flt_dout,
  output logic [D_W-1:0] res_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           res_overrun,
  output logic           err_timeout
);

  localparam int              WD_W     = N_W + 2;
  localparam logic [N_W-1:0]  N_MIN    = N_W'(COI3_N_MIN);
  localparam logic [WD_W-1:0] WD_EXTRA = WD_W'(COI3_SYNC_LAT + TO_MARGIN);

  coi3_ctrl_state_t r_state;
  logic             r_busy;
  logic             r_flt_rst;
  logic             r_clr;
  logic             r_ovr;
  logic             r_tmo;
  logic [N_W-1:0]   r_n;
  logic [WD_W-1:0]  r_wd;
  logic             w_load;
  logic             w_ovr;

  assign w_load = (r_state == ST_CAPTURE) && !abort;

  coi3_result_buf #(.D_W(D_W)) u_buf (
    .clk     (clk),
    .rstb    (rstb),
    .i_load  (w_load),
    .i_din   (flt_dout),
    .i_ready (res_ready),
    .o_data  (res_data),
    .o_valid (res_valid),
    .o_ovr   (w_ovr)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_flt_rst <= 1'b1;
      r_clr     <= 1'b0;
      r_ovr     <= 1'b0;
      r_tmo     <= 1'b0;
      r_n       <= '0;
      r_wd      <= '0;
    end else if (abort) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_flt_rst <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy    <= 1'b0;
          r_flt_rst <= 1'b1;
          if (start) begin
            r_n     <= (n_cfg < N_MIN) ? N_MIN : n_cfg;
            r_ovr   <= 1'b0;
            r_tmo   <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_clr <= 1'b1;
          if (r_clr) r_state <= ST_ARM;
        end
        ST_ARM: begin
          r_wd      <= WD_W'(r_n) + WD_EXTRA;
          r_flt_rst <= 1'b0;
          r_state   <= ST_RUN;
        end
        ST_RUN: begin
          // done wins over an expiring watchdog in the same cycle
          if (flt_done) begin
            r_state <= ST_CAPTURE;
          end else if (r_wd == '0) begin
            r_tmo     <= 1'b1;
            r_busy    <= 1'b0;
            r_flt_rst <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_wd <= r_wd - WD_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (w_ovr) r_ovr <= 1'b1;
          r_flt_rst <= 1'b1;
          r_clr     <= 1'b0;
          if (cont) begin
            r_state <= ST_CLEAR;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_flt_rst <= 1'b1;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign flt_rst     = r_flt_rst;
  assign flt_n       = r_n;
  assign res_overrun = r_ovr;
  assign err_timeout = r_tmo;

endmodule

// File: tb/tb_coi3_conv_ctrl.sv
// Bench for coi3_conv_ctrl with a behavioural filter stub and result-buffer model.
module tb_coi3_conv_ctrl;

  localparam int N_W = 11;
  localparam int D_W = 28;
  localparam int TOM = 8;

  logic           clk;
  logic           rstb;
  logic           start;
  logic           cont;
  logic           abort;
  logic [N_W-1:0] n_cfg;
  logic           busy;
  logic           flt_rst;
  logic [N_W-1:0] flt_n;
  logic           flt_done;
  logic [D_W-1:0] flt_dout;
  logic [D_W-1:0] res_data;
  logic           res_valid;
  logic           res_ready;
  logic           res_overrun;
  logic           err_timeout;

  int n_chk = 0;
  int n_bad = 0;

  // filter stub controls
  int             f_cnt;
  int             f_delay;
  bit             f_dead;
  logic [D_W-1:0] f_val;

  // expected result-buffer and sticky-flag state
  bit             mv;
  logic [D_W-1:0] md;
  bit             movr;
  bit             mtmo;

  coi3_conv_ctrl #(.N_W(N_W), .D_W(D_W), .TO_MARGIN(TOM)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .cont        (cont),
    .abort       (abort),
    .n_cfg       (n_cfg),
    .busy        (busy),
    .flt_rst     (flt_rst),
    .flt_n       (flt_n),
    .flt_done    (flt_done),
    .flt_dout    (flt_dout),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_overrun (res_overrun),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // filter: after release, done rises on the f_delay-th falling edge
  always @(negedge clk) begin
    if (flt_rst) begin
      f_cnt    = 0;
      flt_done <= 1'b0;
      flt_dout <= ~f_val;
    end else if (!f_dead) begin
      f_cnt = f_cnt + 1;
      if (f_cnt == f_delay) begin
        flt_done <= 1'b1;
        flt_dout <= f_val;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench hang");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return flt_rst;
      1:       return res_valid;
      2:       return res_overrun;
      3:       return flt_done;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int lim, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sig(which) !== val && cnt < lim);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    mv = 0;
    check_val("drain_valid", 32'(res_valid), 32'(0));
  endtask

  // mode: 0 nominal, 1 random early, 2 never done, 3 late, 4 last legal cycle, 5 one too late
  task automatic trial(input int n, input int mode, input bit rdy, input bit poke);
    int neff, budget, dly, exp_cnt, cnt;
    bit tmo_exp;
    logic [D_W-1:0] val;
    neff   = (n < 4) ? 4 : n;
    budget = neff + 4 + TOM;
    case (mode)
      0:       dly = neff + 4;
      1:       dly = int'($urandom_range(1, budget + 1));
      2:       dly = 0;
      3:       dly = budget + 2 + int'($urandom_range(0, 5));
      4:       dly = budget + 1;
      default: dly = budget + 2;
    endcase
    f_dead  = (mode == 2);
    f_delay = dly;
    val     = D_W'($urandom);
    f_val   = val;
    tmo_exp = (mode == 2) || (dly > budget + 1);
    exp_cnt = tmo_exp ? budget + 1 : dly + 1;

    res_ready = rdy;
    n_cfg     = N_W'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cfg = N_W'($urandom);
    movr  = 0;
    mtmo  = 0;
    check_val("busy_on", 32'(busy), 32'(1));

    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (flt_rst && cnt < 10);
    check_val("release_lat", 32'(cnt), 32'(3));
    check_val("flt_n", 32'(flt_n), 32'(neff));

    cnt = 0;
    do begin
      tick();
      cnt++;
      start = poke && (cnt == 2) && (exp_cnt > 4);
    end while (busy && cnt < budget + 20);
    start = 1'b0;
    check_val("end_lat", 32'(cnt), 32'(exp_cnt));

    if (tmo_exp) begin
      mtmo = 1;
      if (rdy) mv = 0;
    end else if (!mv || rdy) begin
      mv = 1;
      md = val;
    end else begin
      movr = 1;
    end
    check_val("err_timeout", 32'(err_timeout), 32'(mtmo));
    check_val("res_overrun", 32'(res_overrun), 32'(movr));
    check_val("res_valid", 32'(res_valid), 32'(mv));
    if (mv) check_val("res_data", 32'(res_data), 32'(md));
    check_val("flt_n_hold", 32'(flt_n), 32'(neff));
    res_ready = 1'b0;
    if (poke) begin
      repeat (6) tick();
      check_val("no_requeue", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    int c;
    logic [D_W-1:0] v1, v3;
    rstb = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    n_cfg = '0; res_ready = 1'b0;
    f_dead = 1'b0; f_delay = 1000; f_val = '0;
    mv = 0; md = '0; movr = 0; mtmo = 0;

    repeat (3) tick();
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_flt_rst", 32'(flt_rst), 32'(1));
    check_val("rst_flt_n", 32'(flt_n), 32'(0));
    check_val("rst_res_data", 32'(res_data), 32'(0));
    check_val("rst_res_valid", 32'(res_valid), 32'(0));
    check_val("rst_overrun", 32'(res_overrun), 32'(0));
    check_val("rst_timeout", 32'(err_timeout), 32'(0));
    rstb = 1'b1;
    tick();

    trial(1023, 0, 0, 0);
    trial(8, 2, 0, 0);
    trial(1, 0, 0, 1);
    trial(16, 4, 0, 0);
    trial(16, 5, 1, 0);

    // abort mid-RUN, then a normal conversion
    drain();
    f_dead = 1'b0; f_delay = 104; f_val = D_W'($urandom);
    n_cfg = N_W'(100);
    start = 1'b1;
    tick();
    start = 1'b0; movr = 0; mtmo = 0;
    repeat (49) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_busy", 32'(busy), 32'(0));
    check_val("abort_flt_rst", 32'(flt_rst), 32'(1));
    repeat (120) tick();
    check_val("abort_no_res", 32'(res_valid), 32'(0));
    check_val("abort_no_tmo", 32'(err_timeout), 32'(0));
    trial(100, 0, 0, 0);

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_val("abort_start", 32'(busy), 32'(0));
    tick();
    check_val("abort_start2", 32'(busy), 32'(0));

    // continuous mode with backpressure
    drain();
    v1 = D_W'($urandom);
    f_dead = 1'b0; f_delay = 20; f_val = v1;
    cont = 1'b1; n_cfg = N_W'(16);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(0, 1'b0, 10, c);
    check_val("cont_rel1", 32'(c), 32'(3));
    wait_for(1, 1'b1, 40, c);
    check_val("cont_cap1", 32'(c), 32'(21));
    check_val("cont_data1", 32'(res_data), 32'(v1));
    f_val = D_W'($urandom);
    wait_for(0, 1'b0, 10, c);
    check_val("cont_gap", 32'(c), 32'(3));
    wait_for(2, 1'b1, 40, c);
    check_val("cont_ovr_lat", 32'(c), 32'(21));
    check_val("cont_keep1", 32'(res_data), 32'(v1));
    check_val("cont_valid2", 32'(res_valid), 32'(1));
    v3 = D_W'($urandom);
    f_val = v3;
    wait_for(0, 1'b0, 10, c);
    check_val("cont_gap2", 32'(c), 32'(3));
    wait_for(3, 1'b1, 40, c);
    check_val("cont_done3", 32'(c), 32'(20));
    res_ready = 1'b1; cont = 1'b0;
    tick();
    res_ready = 1'b0;
    check_val("cont_load3", 32'(res_data), 32'(v3));
    check_val("cont_valid3", 32'(res_valid), 32'(1));
    check_val("cont_idle", 32'(busy), 32'(0));
    check_val("cont_ovr_sticky", 32'(res_overrun), 32'(1));
    mv = 1; md = v3; movr = 1; mtmo = 0;

    for (int i = 0; i < 24; i++) begin
      int r, n;
      r = int'($urandom_range(0, 3));
      case (r)
        0:       n = int'($urandom_range(0, 6));
        1:       n = int'($urandom_range(7, 64));
        2:       n = int'($urandom_range(65, 400));
        default: n = int'($urandom_range(0, 30));
      endcase
      if ($urandom_range(0, 2) == 0) drain();
      trial(n, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    trial(2047, 0, 1, 0);

    // asynchronous reset in the middle of CAPTURE
    trial(12, 0, 1, 0);
    f_dead = 1'b0; f_delay = 20; f_val = D_W'($urandom);
    n_cfg = N_W'(16);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    do begin
      tick();
      c++;
    end while (!flt_done && c < 60);
    check_val("arst_done", 32'(c), 32'(23));
    #2;
    rstb = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy), 32'(0));
    check_val("arst_flt_rst", 32'(flt_rst), 32'(1));
    check_val("arst_flt_n", 32'(flt_n), 32'(0));
    check_val("arst_res_data", 32'(res_data), 32'(0));
    check_val("arst_res_valid", 32'(res_valid), 32'(0));
    check_val("arst_overrun", 32'(res_overrun), 32'(0));
    check_val("arst_timeout", 32'(err_timeout), 32'(0));
    tick();
    rstb = 1'b1;
    mv = 0; md = '0; movr = 0; mtmo = 0;
    tick();
    trial(5, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
